line_buf_mem: RTL and testbench

- Memory-side responder for the pipeline's Rd/Wr/Done/Stall/CacheHit memory interface, serving the fetch stage and memory stage.
- Contains a word-addressed backing array with configurable access latency.
- A single 4-word line buffer in front of the array gives single-cycle read hits.
- Reads are line-allocating; writes are write-through and no-allocate.

---
 rtl/line_buf_mem.sv | 115 +++++++++++
 tb/tb_line_buf_mem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/line_buf_mem.sv
// line_buf_mem: memory responder with a single 4-word read line buffer in front of a latency-modelled word array.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   Addr       byte address (bit 0 must be 0)
//   DataIn     write data
//   Rd / Wr    read / write request
//   createdump accepted and ignored
//   DataOut    read data while Done=1, else 0
//   Done       single-cycle completion pulse
//   Stall      responder busy, requester holds its request
//   CacheHit   completion was a line-buffer hit
//   err        illegal request this cycle
module line_buf_mem #(
   parameter int LATENCY   = 2,
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [15:0] LIM = 16'(MEM_WORDS);
   localparam logic [3:0] LAT = 4'(LATENCY);
   typedef enum logic [2:0] {IDLE, RWAIT, FILL, WWAIT, DONE} state_t;
   state_t state;
   logic [15:0] mem [MEM_WORDS];
   logic [15:0] line [4];
   logic [12:0] tag, tag_l;
   logic [1:0] ws_l;
   logic [15:0] dl;
   logic [3:0] cnt;
   logic valid, is_wr, idle, req, bad, hit, unused;
   logic [AW-1:0] fa, wa;
   assign unused = createdump;
   assign fa = AW'({tag_l, cnt[1:0]});
   assign wa = AW'({tag_l, ws_l});
   // Request decode is only live in IDLE with reset released, so reset forces every output low.
   always_comb begin
      idle = rst && state == IDLE;
      req = Rd | Wr;
      bad = idle && ((Rd && Wr) || (req && (Addr[0] || {1'b0, Addr[15:1]} >= LIM)));
      hit = idle && !bad && Rd && valid && tag == Addr[15:3];
      err = bad;
      Done = hit || state == DONE;
      CacheHit = hit;
      Stall = (idle && !bad && req && !hit) || state inside {RWAIT, FILL, WWAIT};
      DataOut = hit ? line[Addr[2:1]] : (state == DONE && !is_wr) ? line[ws_l] : 16'h0000;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         valid <= 1'b0;
         cnt <= 4'd0;
         tag <= '0;
         tag_l <= '0;
         ws_l <= '0;
         dl <= '0;
         is_wr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!bad && Rd && !hit) begin
                  tag_l <= Addr[15:3];
                  ws_l <= Addr[2:1];
                  cnt <= LAT;
                  is_wr <= 1'b0;
                  valid <= 1'b0;
                  state <= RWAIT;
               end else if (!bad && Wr) begin
                  tag_l <= Addr[15:3];
                  ws_l <= Addr[2:1];
                  dl <= DataIn;
                  cnt <= LAT;
                  is_wr <= 1'b1;
                  state <= WWAIT;
               end
            end
            RWAIT: begin
               cnt <= cnt == 4'd1 ? 4'd0 : cnt - 4'd1;
               state <= cnt == 4'd1 ? FILL : RWAIT;
            end
            FILL: begin
               cnt <= cnt + 4'd1;
               if (cnt == 4'd3) begin
                  valid <= 1'b1;
                  tag <= tag_l;
                  state <= DONE;
               end
            end
            WWAIT: begin
               cnt <= cnt - 4'd1;
               state <= cnt == 4'd1 ? DONE : WWAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Array and line data carry no reset; writes are gated by the reset-controlled state.
   always_ff @(posedge clk) begin
      if (state == FILL) line[cnt[1:0]] <= mem[fa];
      if (state == WWAIT && cnt == 4'd1) begin
         mem[wa] <= dl;
         if (valid && tag == tag_l) line[ws_l] <= dl;
      end
   end
endmodule

// File: tb/tb_line_buf_mem.sv
// tb_line_buf_mem: randomized self-checking bench for line_buf_mem against a word-array/line-tag reference model.
module tb_line_buf_mem;
   localparam int L  = 2;
   localparam int MW = 256;
   logic clk = 1'b0, rst = 1'b0;
   logic [15:0] Addr = '0, DataIn = '0;
   logic Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
   logic [15:0] DataOut;
   logic Done, Stall, CacheHit, err;
   int n_chk = 0, n_fail = 0;
   logic [15:0] m_mem [MW];
   logic m_valid = 1'b0;
   logic [12:0] m_tag = '0;
   line_buf_mem #(.LATENCY(L), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
      .CacheHit(CacheHit), .err(err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in();
      Rd = 0; Wr = 0; Addr = '0; DataIn = '0; createdump = 0;
   endtask
   task automatic junk();
      Rd = 1'($urandom); Wr = 1'($urandom); Addr = 16'($urandom);
      DataIn = 16'($urandom); createdump = 1'($urandom);
   endtask
   task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      int w, n;
      bit bad, hit;
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      w = int'(a >> 1);
      bad = (rd && wr) || ((rd || wr) && (a[0] || w >= MW));
      hit = rd && !bad && m_valid && m_tag == a[15:3];
      @(negedge clk);
      if (bad) begin
         chk("ill_err", err, 1);
         chk("ill_done", Done, 0);
         chk("ill_stall", Stall, 0);
         step();
         idle_in();
         return;
      end
      chk("err", err, 0);
      if (!rd && !wr) begin
         chk("idle_ctl", {Done, Stall, CacheHit}, 0);
         chk("idle_data", DataOut, 0);
         step();
         return;
      end
      if (hit) begin
         chk("hit_done", Done, 1);
         chk("hit_ch", CacheHit, 1);
         chk("hit_stall", Stall, 0);
         chk("hit_data", DataOut, m_mem[w]);
         step();
         idle_in();
         return;
      end
      chk("req_stall", Stall, 1);
      chk("req_done", Done, 0);
      n = rd ? L + 4 : L;
      for (int k = 0; k < n; k++) begin
         step();
         junk();
         @(negedge clk);
         chk("busy_stall", Stall, 1);
         chk("busy_done", Done, 0);
      end
      step();
      junk();
      @(negedge clk);
      if (wr) m_mem[w] = d;
      else begin
         m_valid = 1;
         m_tag = a[15:3];
      end
      chk("done", Done, 1);
      chk("done_ch", CacheHit, 0);
      chk("done_stall", Stall, 0);
      chk("done_data", DataOut, rd ? m_mem[w] : 16'h0000);
      step();
      idle_in();
   endtask
   task automatic chk_reset_out(input string tag);
      chk(tag, {Done, Stall, CacheHit, err}, 0);
      chk({tag, "_data"}, DataOut, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int r;
      logic [15:0] a;
      logic [15:0] old;
      Rd = 1; Addr = 16'h0010;
      step();
      @(negedge clk);
      chk_reset_out("rst_out");
      step();
      rst = 1;
      idle_in();
      step();
      for (int i = 0; i < MW; i++) req(0, 1, 16'(i * 2), 16'($urandom));
      rst = 0;
      m_valid = 0;
      step();
      step();
      rst = 1;
      step();
      req(1, 0, 16'h0010, 0);
      req(0, 1, 16'h0020, 16'hBEEF);
      req(1, 0, 16'h0020, 0);
      req(1, 0, 16'h0022, 0);
      req(1, 0, 16'h0026, 0);
      req(0, 1, 16'h0024, 16'h1234);
      req(1, 0, 16'h0024, 0);
      req(0, 1, 16'h0040, 16'h5555);
      req(1, 0, 16'h0022, 0);
      req(1, 0, 16'h0036, 0);
      req(1, 0, 16'h0030, 0);
      req(1, 1, 16'h0030, 0);
      req(1, 0, 16'h0003, 0);
      req(1, 0, 16'h0200, 0);
      req(0, 1, 16'h0201, 16'h7777);
      req(1, 0, 16'h0032, 0);
      // reset during FILL, then the same line must miss again
      Rd = 1; Addr = 16'h0050;
      for (int k = 0; k < 4; k++) step();
      rst = 0;
      #1;
      chk_reset_out("rst_fill");
      m_valid = 0;
      step();
      step();
      rst = 1;
      idle_in();
      step();
      req(1, 0, 16'h0050, 0);
      // reset during WWAIT loses the uncommitted write
      old = m_mem[16'h0060 >> 1];
      Wr = 1; Addr = 16'h0060; DataIn = ~old;
      step();
      rst = 0;
      #1;
      chk_reset_out("rst_wwait");
      m_valid = 0;
      step();
      rst = 1;
      idle_in();
      step();
      req(1, 0, 16'h0060, 0);
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         a = 16'($urandom_range(0, 63) * 2);
         case (r)
            0: req(0, 0, 16'($urandom), 0);
            1, 2, 3, 4, 5: req(1, 0, a, 0);
            6, 7: req(0, 1, a, 16'($urandom));
            8: req(1, 0, 16'($urandom_range(0, MW - 1) * 2), 0);
            default: req(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         endcase
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
